// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port and UART-pin bundle for fifo_uart_tx.
// master: the drain/transmitter side; slave: the FIFO/pin side.
interface fifo_uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 4
);
  logic                  en;
  logic                  empty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rinc;
  logic                  tx;
  logic                  busy;
  logic                  done;

  modport master (
    input  en,
    input  empty,
    input  rdata,
    output rinc,
    output tx,
    output busy,
    output done
  );

  modport slave (
    output en,
    output empty,
    output rdata,
    input  rinc,
    input  tx,
    input  busy,
    input  done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains a first-word-fall-through FIFO and serialises each word as a UART
// frame: start, data LSB first, optional even parity, one stop bit.
module fifo_uart_tx #(
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  fifo_uart_tx_if.master bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]            state, state_d;
  logic [CNT_W-1:0]      bcnt, bcnt_d;
  logic [IDX_W-1:0]      bidx, bidx_d;
  logic [DATA_WIDTH-1:0] shreg, shreg_d;
  logic                  par, par_d;
  logic                  tx_q, tx_d;
  logic                  rinc_q, rinc_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;
  logic                  load;

  assign bit_end = (bcnt == CNT_W'(CLKS_PER_BIT - 1));
  assign load    = bus.en & ~bus.empty;

  // Next-state, counters and next output values
  always_comb begin
    state_d = state;
    bcnt_d  = bit_end ? '0 : bcnt + CNT_W'(1);
    bidx_d  = bidx;
    shreg_d = shreg;
    par_d   = par;
    tx_d    = 1'b1;
    rinc_d  = 1'b0;
    done_d  = 1'b0;

    case (state)
      S_IDLE: begin
        bcnt_d = '0;
        if (load) begin
          state_d = S_START;
          shreg_d = bus.rdata;
          par_d   = ^bus.rdata;
          rinc_d  = 1'b1;
          tx_d    = 1'b0;
          bidx_d  = '0;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          state_d = S_DATA;
          bidx_d  = '0;
          tx_d    = shreg[0];
        end
      end
      S_DATA: begin
        tx_d = shreg[0];
        if (bit_end) begin
          shreg_d = shreg >> 1;
          if (bidx == IDX_W'(DATA_WIDTH - 1)) begin
            bidx_d = '0;
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = par;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bidx_d = bidx + IDX_W'(1);
            tx_d   = shreg_d[0];
          end
        end
      end
      S_PARITY: begin
        tx_d = par;
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          // Chain straight into the next start bit when more data is ready
          if (load) begin
            state_d = S_START;
            shreg_d = bus.rdata;
            par_d   = ^bus.rdata;
            rinc_d  = 1'b1;
            tx_d    = 1'b0;
            bidx_d  = '0;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        bcnt_d  = '0;
        bidx_d  = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      bcnt   <= '0;
      bidx   <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      tx_q   <= 1'b1;
      rinc_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      bcnt   <= bcnt_d;
      bidx   <= bidx_d;
      shreg  <= shreg_d;
      par    <= par_d;
      tx_q   <= tx_d;
      rinc_q <= rinc_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.rinc = rinc_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a parity and a no-parity instance fed by FIFO models,
// with expected nibbles queued on push and checked bit-by-bit when framed.
module tb_fifo_uart_tx;

  localparam int unsigned W = 4;
  localparam int unsigned C = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [W-1:0] fifo1[$];
  logic [W-1:0] fifo0[$];
  logic [W-1:0] sb1[$];
  logic [W-1:0] sb0[$];

  fifo_uart_tx_if #(.DATA_WIDTH(W)) bus1 ();
  fifo_uart_tx_if #(.DATA_WIDTH(W)) bus0 ();

  fifo_uart_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(C), .PARITY_EN(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.master)
  );

  fifo_uart_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(C), .PARITY_EN(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.master)
  );

  always #5 clk = ~clk;

  task automatic refresh();
    bus1.empty = (fifo1.size() == 0);
    bus1.rdata = (fifo1.size() != 0) ? fifo1[0] : '0;
    bus0.empty = (fifo0.size() == 0);
    bus0.rdata = (fifo0.size() != 0) ? fifo0[0] : '0;
  endtask

  // Advance one cycle; the FIFO models honour the pop strobe mid-cycle
  task automatic tick();
    @(negedge clk);
    if (bus1.rinc === 1'b1 && fifo1.size() != 0) void'(fifo1.pop_front());
    if (bus0.rinc === 1'b1 && fifo0.size() != 0) void'(fifo0.pop_front());
    refresh();
  endtask

  task automatic push(input int sel, input logic [W-1:0] d);
    if (sel == 1) begin
      fifo1.push_back(d);
      sb1.push_back(d);
    end else begin
      fifo0.push_back(d);
      sb0.push_back(d);
    end
    refresh();
  endtask

  task automatic sample(input int sel, output logic r, output logic t,
                        output logic b, output logic d);
    if (sel == 1) begin
      r = bus1.rinc; t = bus1.tx; b = bus1.busy; d = bus1.done;
    end else begin
      r = bus0.rinc; t = bus0.tx; b = bus0.busy; d = bus0.done;
    end
  endtask

  // Check nframes back-to-back frames starting next cycle; optionally drop en
  // or assert reset at cycle k of the first frame.
  task automatic expect_frames(input int sel, input int nframes,
                               input int drop_en_k, input int rst_k);
    int           p;
    int           nbits;
    int           len;
    logic [W-1:0] nib;
    logic [15:0]  bv;
    logic         r, t, b, d;
    p     = (sel == 1) ? 1 : 0;
    nbits = 2 + int'(W) + p;
    len   = nbits * int'(C);
    for (int f = 0; f < nframes; f++) begin
      if (sel == 1) nib = sb1.pop_front();
      else          nib = sb0.pop_front();
      bv = '0;
      for (int i = 0; i < int'(W); i++) bv[1+i] = nib[i];
      if (p == 1) bv[1+W] = ^nib;
      bv[nbits-1] = 1'b1;
      for (int k = 0; k < len; k++) begin
        tick();
        sample(sel, r, t, b, d);
        n_checks++;
        if (t !== bv[k/int'(C)]) begin
          n_fail++;
          $display("FAIL tx dut%0d frame%0d cycle%0d: got %b want %b", sel, f, k, t, bv[k/int'(C)]);
        end
        n_checks++;
        if (r !== (k == 0)) begin
          n_fail++;
          $display("FAIL rinc dut%0d frame%0d cycle%0d: got %b want %b", sel, f, k, r, (k == 0));
        end
        n_checks++;
        if (b !== 1'b1) begin
          n_fail++;
          $display("FAIL busy dut%0d frame%0d cycle%0d: got %b want 1", sel, f, k, b);
        end
        n_checks++;
        if (d !== 1'b0) begin
          n_fail++;
          $display("FAIL done_early dut%0d frame%0d cycle%0d: got %b want 0", sel, f, k, d);
        end
        if (f == 0 && k == drop_en_k) begin
          if (sel == 1) bus1.en = 1'b0;
          else          bus0.en = 1'b0;
        end
        if (f == 0 && k == rst_k) begin
          rst_n = 1'b0;
          return;
        end
      end
    end
    tick();
    sample(sel, r, t, b, d);
    n_checks++;
    if (d !== 1'b1 || b !== 1'b0 || t !== 1'b1 || r !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_end dut%0d: got done=%b busy=%b tx=%b rinc=%b want 1 0 1 0", sel, d, b, t, r);
    end
    tick();
    sample(sel, r, t, b, d);
    n_checks++;
    if (d !== 1'b0 || t !== 1'b1) begin
      n_fail++;
      $display("FAIL done_width dut%0d: got done=%b tx=%b want 0 1", sel, d, t);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus1.en = 1'b0;
    bus0.en = 1'b0;
    refresh();
    tick();
    tick();
    n_checks++;
    if (bus1.tx !== 1'b1 || bus1.rinc !== 1'b0 || bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset dut1: got tx=%b rinc=%b busy=%b done=%b want 1 0 0 0",
               bus1.tx, bus1.rinc, bus1.busy, bus1.done);
    end
    n_checks++;
    if (bus0.tx !== 1'b1 || bus0.rinc !== 1'b0 || bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset dut0: got tx=%b rinc=%b busy=%b done=%b want 1 0 0 0",
               bus0.tx, bus0.rinc, bus0.busy, bus0.done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    bus1.en = 1'b1;
    push(1, 4'hA);
    expect_frames(1, 1, -1, -1);
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (bus1.tx !== 1'b1 || bus1.rinc !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after dut1 cycle%0d: got tx=%b rinc=%b want 1 0", i, bus1.tx, bus1.rinc);
      end
    end
  endtask

  task automatic test_parity();
    push(1, 4'h7);
    expect_frames(1, 1, -1, -1);
    bus0.en = 1'b1;
    push(0, 4'h7);
    expect_frames(0, 1, -1, -1);
    bus0.en = 1'b0;
    push(1, 4'hE);
    expect_frames(1, 1, -1, -1);
  endtask

  task automatic test_back_to_back();
    push(1, 4'h1);
    push(1, 4'h2);
    push(1, 4'h3);
    expect_frames(1, 3, -1, -1);
  endtask

  task automatic test_gating();
    bus1.en = 1'b0;
    push(1, 4'h5);
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++;
      if (bus1.tx !== 1'b1 || bus1.rinc !== 1'b0 || bus1.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL gated dut1 cycle%0d: got tx=%b rinc=%b busy=%b want 1 0 0",
                 i, bus1.tx, bus1.rinc, bus1.busy);
      end
    end
    bus1.en = 1'b1;
    expect_frames(1, 1, -1, -1);
  endtask

  task automatic test_en_mid_frame();
    push(1, 4'h3);
    push(1, 4'hC);
    expect_frames(1, 1, 2 * int'(C) + 1, -1);
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++;
      if (bus1.tx !== 1'b1 || bus1.rinc !== 1'b0) begin
        n_fail++;
        $display("FAIL en_low_idle dut1 cycle%0d: got tx=%b rinc=%b want 1 0", i, bus1.tx, bus1.rinc);
      end
    end
    n_checks++;
    if (fifo1.size() != 1) begin
      n_fail++;
      $display("FAIL en_low_pops: got %0d words left want 1", fifo1.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    push(1, 4'h6);
    bus1.en = 1'b1;
    expect_frames(1, 1, -1, 5 * int'(C) + 1);
    tick();
    n_checks++;
    if (bus1.tx !== 1'b1 || bus1.busy !== 1'b0 || bus1.rinc !== 1'b0 || bus1.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid dut1: got tx=%b busy=%b rinc=%b done=%b want 1 0 0 0",
               bus1.tx, bus1.busy, bus1.rinc, bus1.done);
    end
    tick();
    rst_n = 1'b1;
    expect_frames(1, 1, -1, -1);
    n_checks++;
    if (fifo1.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_drain: got %0d words left want 0", fifo1.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_gating();
    test_en_mid_frame();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the 4-bit FIFO read port. It runs on the FIFO read clock, pops one nibble whenever the FIFO is non-empty and transmission is enabled, and serialises it as a UART frame on a single output pin. The frame is start bit, DATA_WIDTH data bits LSB first, optional even parity, then one stop bit. It replaces manual `rinc` toggling so the design can be read back over one wire.

## Interface
- `DATA_WIDTH`, 4: nibble width; matches FIFO data width.
- `CLKS_PER_BIT`, 8: `clk` cycles per UART bit; legal range is 2 to 255.
- `PARITY_EN`, 1: 1 inserts an even-parity bit; 0 omits it.

Ports:
- `clk`  in  1  FIFO read clock (`rclk`); single clock domain for this block.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  permits new frames to start; does not abort a frame in progress.
- `empty`  in  1  FIFO empty flag, in the `clk` domain.
- `rdata`  in  DATA_WIDTH  FIFO head word; valid whenever `empty`=0 (first-word fall-through).
- `rinc`  out  1  pop strobe to the FIFO; one-cycle pulse per frame.
- `tx`  out  1  serial output; idle high.
- `busy`  out  1  high while a frame is on `tx`.
- `done`  out  1  one-cycle pulse after the stop bit of the last frame in a burst completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - Baud counter `bcnt`, width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1.
  - Bit index `bidx`, counts 0..DATA_WIDTH-1.
  - Each state other than IDLE holds for one full bit time per bit.
- Load condition: `en` & ~`empty`, evaluated in IDLE, or in the last cycle of STOP (`bcnt`=CLKS_PER_BIT-1).
- On load, at the next edge:
  - `shreg` captures `rdata`.
  - `par` captures ^`rdata`.
  - `rinc` becomes 1.
  - `tx` becomes 0.
  - state becomes START.
- Transitions:
  - START goes to DATA.
  - DATA shifts `shreg` right once per bit; after DATA_WIDTH bits it goes to PARITY (PARITY_EN=1) or STOP.
  - PARITY goes to STOP.
  - STOP goes to START if the load condition holds; otherwise it goes to IDLE with `done` pulsed.
- `tx` per state: IDLE 1, START 0, DATA `shreg[0]`, PARITY `par`, STOP 1. `tx` is registered.
- Even parity: total count of ones across the data bits and the parity bit is even.
- `en` deasserted mid-frame: the current frame completes; no further load occurs.
- `empty` rising mid-frame has no effect on the current frame.
- Reset (any cycle, including mid-frame):
  - State returns to IDLE.
  - `tx`=1, `rinc`=0, `busy`=0, `done`=0, counters 0.
  - A nibble that was already popped is discarded.

## Timing
- Let N be the IDLE cycle in which `en`=1 and `empty`=0; let C = CLKS_PER_BIT and P = PARITY_EN.
- `rinc`=1 in cycle N+1 only, giving exactly one pop per frame. The FIFO flag update (≤1 cycle) lands before the next load check, because C≥2.
- `tx`=0 during cycles N+1 .. N+C.
- Data bit i is on `tx` during cycles N+1+(1+i)C .. N+(2+i)C.
- With P=1, parity occupies cycles N+1+5C .. N+6C.
- Stop bit occupies the following C cycles.
- Frame length is (2+DATA_WIDTH+P)·C cycles: 7C with parity, 6C without.
- `busy`=1 from cycle N+1 through the last stop cycle.
- `done`=1 in the cycle after the last stop cycle, and only when the FSM returns to IDLE.
- Back-to-back frames:
  - The next start bit begins immediately after the previous stop bit; there is no idle gap.
  - `rinc` pulses at the first start-bit cycle of each frame.
  - `busy` stays high across the burst; `done` pulses once at the end of the burst.
- Latency from `empty` falling to `tx` falling is 1 cycle, when IDLE and `en`=1.

## Test plan
- Reset, single frame: C=4, P=1, `rst_n` low for 2 cycles, then `empty`=0 with `rdata`=0xA.
  - `rinc` pulses once.
  - `tx` bits, 4 cycles each: 0,0,1,0,1,0,1.
  - `busy` is high for 28 cycles; `done` pulses once; `tx` then stays 1.
- Parity check: P=1, `rdata`=0x7. Bits are 0,1,1,1,0,1,1 (parity=1). The same nibble with P=0 gives 0,1,1,1,0,1 over 24 cycles.
- Burst: three nibbles 0x1, 0x2, 0x3 in the FIFO, C=4.
  - `rinc` pulses at cycles N+1, N+29, N+57.
  - `tx` never goes idle-high between frames.
  - A single `done` pulse follows at N+85.
- Gating: `en`=0 with `empty`=0. `tx` stays 1 and `rinc` stays 0 indefinitely.
- Gating mid-frame: drop `en` during DATA with more data queued. The current frame finishes, `done` pulses, and no further pop occurs.
- Reset mid-frame: assert `rst_n`=0 during PARITY.
  - At the next edge `tx`=1 and `busy`=0.
  - After release with `empty`=0, a fresh frame starts with the next FIFO word.
